// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT output reorder stage: bit reversal,
// frame-state encoding and real/imaginary slicing of packed samples.
package fft_pkg;

  localparam int MAX_LGSIZE = 16;
  localparam int MAX_WIDTH  = 32;

  typedef enum logic {
    WAIT_SYNC,
    RUN
  } frame_state_e;

  // Reverses the low lgsize bits of idx; bits above lgsize come back as zero.
  function automatic logic [MAX_LGSIZE-1:0] bitrev(input logic [MAX_LGSIZE-1:0] idx,
                                                   input int lgsize);
    logic [MAX_LGSIZE-1:0] v;
    logic [MAX_LGSIZE-1:0] r;
    v = idx;
    r = '0;
    for (int i = 0; i < MAX_LGSIZE; i++) begin
      if (i < lgsize) begin
        r = {r[MAX_LGSIZE-2:0], v[0]};
        v = v >> 1;
      end
    end
    return r;
  endfunction

  // Packed sample layout: real in the high half, imaginary in the low half.
  function automatic logic [MAX_WIDTH-1:0] sample_re(input logic [2*MAX_WIDTH-1:0] s,
                                                     input int width);
    logic [2*MAX_WIDTH-1:0] mask;
    mask = (64'd1 << width) - 64'd1;
    return MAX_WIDTH'((s >> width) & mask);
  endfunction

  function automatic logic [MAX_WIDTH-1:0] sample_im(input logic [2*MAX_WIDTH-1:0] s,
                                                     input int width);
    logic [2*MAX_WIDTH-1:0] mask;
    mask = (64'd1 << width) - 64'd1;
    return MAX_WIDTH'(s & mask);
  endfunction

endpackage

// File: rtl/fft_bitrev_dpram.sv
// Simple dual-port RAM holding both ping-pong banks; address = {bank, index}.
// One write port, one registered read port, shaped for block-RAM inference.
module fft_bitrev_dpram #(
  parameter int AW = 4,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  // NOTE: no reset on the array or read register -- a reset term would stop
  // block-RAM inference; per-bank valid flags in the control logic mask stale data.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fft_bitreverse.sv
// Output reorder stage: converts the bit-reversed stream from the last FFT
// butterfly into natural order, with a per-frame arrival-order bypass.
module fft_bitreverse
  import fft_pkg::*;
#(
  parameter int LGSIZE = 12,
  parameter int WIDTH  = 16
) (
  input  logic               i_clk,
  input  logic               i_areset_n,
  input  logic               i_ce,
  input  logic               i_sync,
  input  logic               i_bypass,
  input  logic [2*WIDTH-1:0] i_sample,
  output logic [2*WIDTH-1:0] o_result,
  output logic               o_sync,
  output logic               o_frame_err
);

  localparam logic [LGSIZE-1:0] LAST = '1;

  frame_state_e      state_q, state_d;
  logic [LGSIZE-1:0] cnt_q;
  logic              wb_q;
  logic [1:0]        valid_q;
  logic [1:0]        bypass_flag_q;
  logic              bypass_lat_q;
  logic              rd_valid_q;
  logic              sync_q;
  logic              err_q;

  logic              accept;
  logic              early;
  logic              wrap;
  logic [LGSIZE-1:0] pos;
  logic [LGSIZE-1:0] rd_idx;
  logic              wbank;
  logic              rbank;
  logic              rd_valid_d;
  logic [2*WIDTH-1:0] rdata;

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    early   = 1'b0;
    wrap    = 1'b0;
    pos     = cnt_q;
    wbank   = wb_q;

    case (state_q)
      WAIT_SYNC: begin
        if (i_ce && i_sync) begin
          state_d = RUN;
          accept  = 1'b1;
        end
      end
      RUN: begin
        if (i_ce) begin
          accept = 1'b1;
          early  = i_sync && (cnt_q != '0);
          wrap   = !early && (cnt_q == LAST);
        end
      end
      default: state_d = WAIT_SYNC;
    endcase

    // An early sync abandons the current write bank and restarts in the other one.
    if (early) begin
      pos   = '0;
      wbank = !wb_q;
    end

    rbank      = !wbank;
    rd_idx     = bypass_flag_q[rbank] ? pos
                                      : LGSIZE'(bitrev(MAX_LGSIZE'(pos), LGSIZE));
    rd_valid_d = valid_q[rbank] && !early;
  end

  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      state_q <= WAIT_SYNC;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: non-blocking assignments throughout, so every flag here updates from
  // the same pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      cnt_q         <= '0;
      wb_q          <= 1'b0;
      valid_q       <= '0;
      bypass_flag_q <= '0;
      bypass_lat_q  <= 1'b0;
      rd_valid_q    <= 1'b0;
      sync_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      if (accept) begin
        cnt_q <= pos + LGSIZE'(1);
        if (i_sync) bypass_lat_q <= i_bypass;
      end

      if (early) begin
        valid_q[wb_q] <= 1'b0;
        wb_q          <= !wb_q;
      end else if (wrap) begin
        valid_q[wb_q]       <= 1'b1;
        bypass_flag_q[wb_q] <= bypass_lat_q;
        wb_q                <= !wb_q;
      end

      if (i_ce) begin
        rd_valid_q <= accept && rd_valid_d;
        sync_q     <= accept && rd_valid_d && (pos == '0);
      end

      err_q <= early;
    end
  end

  fft_bitrev_dpram #(
    .AW(LGSIZE + 1),
    .DW(2 * WIDTH)
  ) u_ram (
    .clk  (i_clk),
    .we   (accept),
    .waddr({wbank, pos}),
    .wdata(i_sample),
    .re   (accept),
    .raddr({rbank, rd_idx}),
    .rdata(rdata)
  );

  // Invalid banks and reset both force a zero output without touching the RAM.
  assign o_result    = rd_valid_q ? rdata : '0;
  assign o_sync      = sync_q;
  assign o_frame_err = err_q;

endmodule

// File: tb/tb_fft_bitreverse.sv
// Scoreboard bench for fft_bitreverse with N=8: the driver queues the
// hand-derived output for each i_ce cycle, the monitor pops and compares.
module tb_fft_bitreverse;

  localparam int LGSIZE = 3;
  localparam int WIDTH  = 16;

  typedef struct packed {
    logic [2*WIDTH-1:0] res;
    logic               sync;
    logic               err;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               i_ce;
  logic               i_sync;
  logic               i_bypass;
  logic [2*WIDTH-1:0] i_sample;
  logic [2*WIDTH-1:0] o_result;
  logic               o_sync;
  logic               o_frame_err;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];
  int   rev [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  fft_bitreverse #(
    .LGSIZE(LGSIZE),
    .WIDTH (WIDTH)
  ) dut (
    .i_clk      (clk),
    .i_areset_n (rst_n),
    .i_ce       (i_ce),
    .i_sync     (i_sync),
    .i_bypass   (i_bypass),
    .i_sample   (i_sample),
    .o_result   (o_result),
    .o_sync     (o_sync),
    .o_frame_err(o_frame_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, pending=%0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
    end
  endtask

  function automatic logic [2*WIDTH-1:0] mk(input int v);
    return {v[15:0], v[15:0] ^ 16'hA5A5};
  endfunction

  // Monitor: one expected entry per accepted i_ce edge; outputs hold otherwise.
  always @(posedge clk) begin
    logic ce_s;
    logic rst_s;
    exp_t e;
    exp_t last;
    ce_s  = i_ce;
    rst_s = rst_n;
    #1;
    if (!rst_s || !rst_n) begin
      last = '0;
    end else if (ce_s) begin
      if (exp_q.size() == 0) begin
        check("scoreboard_underflow", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("result", 64'(o_result), 64'(e.res));
        check("sync", 64'(o_sync), 64'(e.sync));
        check("frame_err", 64'(o_frame_err), 64'(e.err));
        last = e;
      end
    end else begin
      check("hold_result", 64'(o_result), 64'(last.res));
      check("hold_sync", 64'(o_sync), 64'(last.sync));
      check("idle_frame_err", 64'(o_frame_err), 64'd0);
    end
  end

  task automatic drive(input logic ce, input logic sync, input logic byp,
                       input logic [2*WIDTH-1:0] smp, input logic [2*WIDTH-1:0] eres,
                       input logic esync, input logic eerr);
    @(negedge clk);
    i_ce     = ce;
    i_sync   = sync;
    i_bypass = byp;
    i_sample = smp;
    if (ce) exp_q.push_back('{eres, esync, eerr});
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  // kind: 0 = expect zeros, 1 = expect exp_base+rev[j], 2 = expect exp_base+j.
  // i_bypass is inverted on non-sync samples to show it is ignored there.
  task automatic frame(input int base, input logic byp, input int kind, input int exp_base,
                       input bit rand_ce, input logic first_err);
    logic [2*WIDTH-1:0] er;
    for (int j = 0; j < 8; j++) begin
      if (rand_ce && $urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
      case (kind)
        1:       er = mk(exp_base + rev[j]);
        2:       er = mk(exp_base + j);
        default: er = '0;
      endcase
      drive(1'b1, j == 0, (j == 0) ? byp : !byp, mk(base + j), er,
            (kind != 0) && (j == 0), first_err && (j == 0));
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    i_ce     = 1'b0;
    i_sync   = 1'b0;
    i_bypass = 1'b0;
    i_sample = '0;
    #2;
    check("reset_result", 64'(o_result), 64'd0);
    check("reset_sync", 64'(o_sync), 64'd0);
    check("reset_frame_err", 64'(o_frame_err), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Pre-sync garbage must never surface.
    repeat (3) drive(1'b1, 1'b0, 1'b0, 32'h0000DEAD, 32'h0, 1'b0, 1'b0);
    frame(0,  1'b0, 0, 0,  1'b0, 1'b0);
    frame(8,  1'b0, 1, 0,  1'b0, 1'b0);
    frame(16, 1'b1, 1, 8,  1'b0, 1'b0);
    frame(24, 1'b0, 2, 16, 1'b1, 1'b0);

    // Early sync at count 5: first five positions still read frame 24.
    for (int j = 0; j < 5; j++)
      drive(1'b1, j == 0, 1'b0, mk(32 + j), mk(24 + rev[j]), j == 0, 1'b0);
    frame(40, 1'b0, 0, 0,  1'b0, 1'b1);
    frame(48, 1'b0, 1, 40, 1'b0, 1'b0);

    // Mid-frame asynchronous reset.
    for (int j = 0; j < 3; j++)
      drive(1'b1, j == 0, 1'b0, mk(56 + j), mk(48 + rev[j]), j == 0, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    i_ce  = 1'b0;
    #1;
    check("async_reset_result", 64'(o_result), 64'd0);
    check("async_reset_sync", 64'(o_sync), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    repeat (2) drive(1'b1, 1'b0, 1'b0, 32'h0000DEAD, 32'h0, 1'b0, 1'b0);
    frame(100, 1'b0, 0, 0,   1'b0, 1'b0);
    frame(108, 1'b0, 1, 100, 1'b0, 1'b0);
    idle(3);

    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
